rename_reg_file: RTL and testbench
==================================

RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 The block SHALL have parameter ROB_WIDTH, default 3, giving the ROB tag width.
REQ-002 The block SHALL have parameter RS_WIDTH, default 2, giving the RS index width.
REQ-003 The block SHALL have parameter NUM_RD, default 2, giving the number of read ports (1..4).
REQ-004 The block SHALL have port clk_in, input, 1 bit, the clock.
REQ-005 The block SHALL have port rst_in, input, 1 bit, the reset: asynchronous, active-high.
REQ-006 The block SHALL have port rdy_in, input, 1 bit, the global enable.
REQ-007 The block SHALL have port issue_valid, input, 1 bit, marking a destination register as renamed.
REQ-008 The block SHALL have port issue_rd, input, 5 bits, the renamed destination register.
REQ-009 The block SHALL have port issue_tag, input, ROB_WIDTH bits, the ROB entry producing issue_rd.
REQ-010 The block SHALL have port rd_req, input, NUM_RD bits, one read request per port.
REQ-011 The block SHALL have port rd_addr, input, NUM_RD*5 bits, the per-port register address; port p uses bits [5p+4:5p].
REQ-012 The block SHALL have port rd_index, input, RS_WIDTH bits, the requesting RS slot, shared by all ports.
REQ-013 The block SHALL have port commit_valid, input, 1 bit, the ROB commit strobe.
REQ-014 The block SHALL have port commit_rd, input, 5 bits, the commit destination register.
REQ-015 The block SHALL have port commit_tag, input, ROB_WIDTH bits, the ROB tag of the committing entry.
REQ-016 The block SHALL have port commit_data, input, 32 bits, the commit write data.
REQ-017 The block SHALL have port flush, input, 1 bit, the mispredict flush.
REQ-018 The block SHALL have port rd_resp_valid, output, NUM_RD bits, the per-port response pulse.
REQ-019 The block SHALL have port rd_resp_busy, output, NUM_RD bits, set when the register value is pending.
REQ-020 The block SHALL have port rd_resp_tag, output, NUM_RD*ROB_WIDTH bits, the producer tag, meaningful only when busy.
REQ-021 The block SHALL have port rd_resp_data, output, NUM_RD*32 bits, the register value.
REQ-022 The block SHALL have port rd_resp_index, output, RS_WIDTH bits, the echoed rd_index.

Function
REQ-023 The block SHALL hold 32x32-bit data plus a per-register busy bit and ROB_WIDTH tag.
REQ-024 Reads SHALL take exactly 1 cycle: a request at edge N produces a response valid for the single cycle after edge N; rd_resp_index SHALL update whenever any rd_req bit is set.
REQ-025 A response SHALL reflect state before any same-cycle issue, so an instruction reads its sources before its own destination is renamed.
REQ-026 issue_valid with issue_rd!=0 SHALL set busy[issue_rd]=1 and tag[issue_rd]=issue_tag.
REQ-027 commit_valid with commit_rd!=0 SHALL write commit_data, and SHALL clear busy only when busy=1 and tag==commit_tag.
REQ-028 When issue and commit target the same register in the same cycle, the data SHALL be written and the issue SHALL win busy/tag.
REQ-029 flush SHALL clear all busy bits and take precedence over a same-cycle issue; a same-cycle commit data write SHALL still occur.
REQ-030 x0 SHALL read 0, never be busy, and ignore writes.
REQ-031 With rdy_in=0, no state SHALL change and rd_resp_valid SHALL be 0 on the next edge.

Reset
REQ-032 rst_in SHALL asynchronously clear all data, busy, and tag bits and drive rd_resp_valid, rd_resp_busy, rd_resp_tag, rd_resp_data, and rd_resp_index to 0, regardless of rdy_in.
REQ-033 Requests in flight at reset SHALL be discarded with no response.

Configuration
REQ-034 With macro RENAME_REG_FILE_BYPASS_EN defined, a read of a register committed in the same cycle SHALL return commit_data and busy after the tag match.
REQ-035 Without RENAME_REG_FILE_BYPASS_EN, such a read SHALL return the pre-commit data, busy, and tag.

Verification
REQ-036 Scenario: reset, then rd_req=2'b11, rd_addr={5'd2,5'd1} -> next cycle valid=2'b11, data 0, busy 0.
REQ-037 Scenario: issue rd=5 tag=3; next cycle read r5 -> busy=1, tag=3; commit rd=5 tag=3 data=0xDEAD; read -> busy=0, data=0xDEAD.
REQ-038 Scenario: issue r5 tag=3, then issue r5 tag=6; commit tag=3 data=0x11 -> data=0x11, busy=1, tag=6.
REQ-039 Scenario: same-cycle issue r7 tag=2 and read r7 -> busy=0; next read -> busy=1, tag=2.
REQ-040 Scenario: busy r3/r4, then flush with same-cycle issue r3 tag=1 -> reads show r3 and r4 not busy; write to x0 -> x0 reads 0.
REQ-041 Scenario: commit r9 data=0x55 with same-cycle read of r9 -> 0x55 with the BYPASS_EN macro defined, old value without it.

Source files
------------

// File: rtl/rename_reg_file.sv
// Rename register file: 32 x 32-bit architectural registers, each carrying a
// busy bit and the ROB tag of its pending producer. NUM_RD read ports answer
// one cycle after the request with the pre-issue view of the register state.
// Optional feature: define RENAME_REG_FILE_BYPASS_EN to forward a same-cycle
// commit (data and busy-clear) into the read response.
module rename_reg_file #(
    parameter int ROB_WIDTH = 3,
    parameter int RS_WIDTH  = 2,
    parameter int NUM_RD    = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    input  logic [ROB_WIDTH-1:0]          issue_tag,
    input  logic [NUM_RD-1:0]             rd_req,
    input  logic [NUM_RD*5-1:0]           rd_addr,
    input  logic [RS_WIDTH-1:0]           rd_index,
    input  logic                          commit_valid,
    input  logic [4:0]                    commit_rd,
    input  logic [ROB_WIDTH-1:0]          commit_tag,
    input  logic [31:0]                   commit_data,
    input  logic                          flush,
    output logic [NUM_RD-1:0]             rd_resp_valid,
    output logic [NUM_RD-1:0]             rd_resp_busy,
    output logic [NUM_RD*ROB_WIDTH-1:0]   rd_resp_tag,
    output logic [NUM_RD*32-1:0]          rd_resp_data,
    output logic [RS_WIDTH-1:0]           rd_resp_index
);

    // Architectural state
    logic [31:0]          r_data [32];
    logic                 r_busy [32];
    logic [ROB_WIDTH-1:0] r_tag  [32];

    // Response registers
    logic [NUM_RD-1:0]           r_resp_valid;
    logic [NUM_RD-1:0]           r_resp_busy;
    logic [NUM_RD*ROB_WIDTH-1:0] r_resp_tag;
    logic [NUM_RD*32-1:0]        r_resp_data;
    logic [RS_WIDTH-1:0]         r_resp_index;

    // Per-port lookup of the current state
    logic [31:0]          w_rd_data [NUM_RD];
    logic                 w_rd_busy [NUM_RD];
    logic [ROB_WIDTH-1:0] w_rd_tag  [NUM_RD];

    // Register update: issue renames, commit writes data and retires matching tags, flush clears busy
    // NOTE: the whole array sits under the async reset because all data, busy and tag bits must
    // clear on reset; this rules out a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                r_data[i] <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            // x0 (i = 0) is never written, so it always reads zero and never busy
            for (int i = 1; i < 32; i++) begin
                if (commit_valid && commit_rd == 5'(i))
                    r_data[i] <= commit_data;
                if (flush)
                    r_busy[i] <= 1'b0;
                else if (issue_valid && issue_rd == 5'(i)) begin
                    // issue wins over a same-cycle commit to the same register
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= issue_tag;
                end else if (commit_valid && commit_rd == 5'(i) && r_busy[i] && r_tag[i] == commit_tag)
                    r_busy[i] <= 1'b0;
            end
        end
    end

    // Read lookup: pre-issue state, optionally with the same-cycle commit forwarded
    // NOTE: every output of this block gets a default before any condition so no latch is inferred.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_data[p] = r_data[rd_addr[5*p +: 5]];
            w_rd_busy[p] = r_busy[rd_addr[5*p +: 5]];
            w_rd_tag[p]  = r_tag[rd_addr[5*p +: 5]];
`ifdef RENAME_REG_FILE_BYPASS_EN
            if (commit_valid && commit_rd != 5'd0 && commit_rd == rd_addr[5*p +: 5]) begin
                w_rd_data[p] = commit_data;
                if (w_rd_busy[p] && w_rd_tag[p] == commit_tag)
                    w_rd_busy[p] = 1'b0;
            end
`endif
        end
    end

    // Response pipeline: one-cycle valid pulse per port, payload captured on request
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_resp_valid <= '0;
            r_resp_busy  <= '0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
            r_resp_index <= '0;
        end else if (!rdy_in) begin
            r_resp_valid <= '0;
        end else begin
            r_resp_valid <= rd_req;
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_req[p]) begin
                    r_resp_busy[p]                       <= w_rd_busy[p];
                    r_resp_tag[p*ROB_WIDTH +: ROB_WIDTH] <= w_rd_tag[p];
                    r_resp_data[p*32 +: 32]              <= w_rd_data[p];
                end
            end
            if (|rd_req)
                r_resp_index <= rd_index;
        end
    end

    assign rd_resp_valid = r_resp_valid;
    assign rd_resp_busy  = r_resp_busy;
    assign rd_resp_tag   = r_resp_tag;
    assign rd_resp_data  = r_resp_data;
    assign rd_resp_index = r_resp_index;

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_rename_reg_file;

    localparam int ROB_WIDTH = 3;
    localparam int RS_WIDTH  = 2;
    localparam int NUM_RD    = 2;

    logic                        clk_in = 1'b0;
    logic                        rst_in;
    logic                        rdy_in;
    logic                        issue_valid;
    logic [4:0]                  issue_rd;
    logic [ROB_WIDTH-1:0]        issue_tag;
    logic [NUM_RD-1:0]           rd_req;
    logic [NUM_RD*5-1:0]         rd_addr;
    logic [RS_WIDTH-1:0]         rd_index;
    logic                        commit_valid;
    logic [4:0]                  commit_rd;
    logic [ROB_WIDTH-1:0]        commit_tag;
    logic [31:0]                 commit_data;
    logic                        flush;
    logic [NUM_RD-1:0]           rd_resp_valid;
    logic [NUM_RD-1:0]           rd_resp_busy;
    logic [NUM_RD*ROB_WIDTH-1:0] rd_resp_tag;
    logic [NUM_RD*32-1:0]        rd_resp_data;
    logic [RS_WIDTH-1:0]         rd_resp_index;

    int n_tests = 0;
    int n_fail  = 0;

    rename_reg_file #(
        .ROB_WIDTH(ROB_WIDTH),
        .RS_WIDTH (RS_WIDTH),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_index     (rd_index),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .flush        (flush),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_busy (rd_resp_busy),
        .rd_resp_tag  (rd_resp_tag),
        .rd_resp_data (rd_resp_data),
        .rd_resp_index(rd_resp_index)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_rd     = '0;
        issue_tag    = '0;
        rd_req       = '0;
        rd_addr      = '0;
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_tag   = '0;
        commit_data  = '0;
        flush        = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] tag);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_tag   = tag;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] tag, input logic [31:0] data);
        commit_valid = 1'b1;
        commit_rd    = rd;
        commit_tag   = tag;
        commit_data  = data;
    endtask

    task automatic do_read(input logic [1:0] req, input logic [4:0] a1, input logic [4:0] a0,
                           input logic [RS_WIDTH-1:0] idx);
        rd_req   = req;
        rd_addr  = {a1, a0};
        rd_index = idx;
    endtask

    initial begin
        idle();
        rd_index = '0;
        rdy_in   = 1'b1;
        rst_in   = 1'b1;
        cycle();
        cycle();
        check("reset_valid", 64'(rd_resp_valid), 64'd0);
        check("reset_index", 64'(rd_resp_index), 64'd0);
        rst_in = 1'b0;

        // Both ports read after reset
        do_read(2'b11, 5'd2, 5'd1, 2'd2);
        cycle();
        check("first_valid", 64'(rd_resp_valid), 64'h3);
        check("first_data",  64'(rd_resp_data),  64'h0);
        check("first_busy",  64'(rd_resp_busy),  64'h0);
        check("first_index", 64'(rd_resp_index), 64'h2);
        idle();
        cycle();
        check("valid_pulse", 64'(rd_resp_valid), 64'h0);

        // Issue then commit with matching tag
        do_issue(5'd5, 3'd3);
        cycle();
        idle();
        do_read(2'b01, 5'd0, 5'd5, 2'd1);
        cycle();
        check("r5_valid", 64'(rd_resp_valid), 64'h1);
        check("r5_busy",  64'(rd_resp_busy[0]), 64'h1);
        check("r5_tag",   64'(rd_resp_tag[2:0]), 64'h3);
        idle();
        do_commit(5'd5, 3'd3, 32'hDEAD);
        cycle();
        idle();
        do_read(2'b01, 5'd0, 5'd5, 2'd1);
        cycle();
        check("r5_commit_busy", 64'(rd_resp_busy[0]), 64'h0);
        check("r5_commit_data", 64'(rd_resp_data[31:0]), 64'hDEAD);

        // Stale commit writes data but leaves the newer rename busy
        idle();
        do_issue(5'd5, 3'd3);
        cycle();
        do_issue(5'd5, 3'd6);
        cycle();
        idle();
        do_commit(5'd5, 3'd3, 32'h11);
        cycle();
        idle();
        do_read(2'b10, 5'd5, 5'd0, 2'd3);
        cycle();
        check("stale_valid", 64'(rd_resp_valid), 64'h2);
        check("stale_data",  64'(rd_resp_data[63:32]), 64'h11);
        check("stale_busy",  64'(rd_resp_busy[1]), 64'h1);
        check("stale_tag",   64'(rd_resp_tag[5:3]), 64'h6);
        idle();
        do_commit(5'd5, 3'd6, 32'h22);
        cycle();

        // Same-cycle issue and read sees pre-issue state
        idle();
        do_issue(5'd7, 3'd2);
        do_read(2'b01, 5'd0, 5'd7, 2'd0);
        cycle();
        check("r7_same_busy", 64'(rd_resp_busy[0]), 64'h0);
        idle();
        do_read(2'b01, 5'd0, 5'd7, 2'd0);
        cycle();
        check("r7_next_busy", 64'(rd_resp_busy[0]), 64'h1);
        check("r7_next_tag",  64'(rd_resp_tag[2:0]), 64'h2);

        // Flush beats a same-cycle issue
        idle();
        do_issue(5'd3, 3'd4);
        cycle();
        do_issue(5'd4, 3'd5);
        cycle();
        idle();
        do_read(2'b11, 5'd4, 5'd3, 2'd0);
        cycle();
        check("r3r4_busy", 64'(rd_resp_busy), 64'h3);
        check("r3r4_tag",  64'(rd_resp_tag), 64'({3'd5, 3'd4}));
        idle();
        flush = 1'b1;
        do_issue(5'd3, 3'd1);
        do_commit(5'd10, 3'd0, 32'hABC);
        cycle();
        idle();
        do_read(2'b11, 5'd4, 5'd3, 2'd0);
        cycle();
        check("flush_busy", 64'(rd_resp_busy), 64'h0);
        idle();
        do_read(2'b01, 5'd0, 5'd10, 2'd0);
        cycle();
        check("flush_commit_data", 64'(rd_resp_data[31:0]), 64'hABC);

        // x0 ignores writes and renames
        idle();
        do_commit(5'd0, 3'd0, 32'hFFFF);
        do_issue(5'd0, 3'd7);
        cycle();
        idle();
        do_read(2'b11, 5'd0, 5'd0, 2'd0);
        cycle();
        check("x0_data", 64'(rd_resp_data), 64'h0);
        check("x0_busy", 64'(rd_resp_busy), 64'h0);

        // Commit and read of the same register in one cycle
        idle();
        do_commit(5'd9, 3'd0, 32'h44);
        cycle();
        idle();
        do_commit(5'd9, 3'd0, 32'h55);
        do_read(2'b01, 5'd0, 5'd9, 2'd0);
        cycle();
`ifdef RENAME_REG_FILE_BYPASS_EN
        check("r9_same_data", 64'(rd_resp_data[31:0]), 64'h55);
`else
        check("r9_same_data", 64'(rd_resp_data[31:0]), 64'h44);
`endif
        idle();
        do_read(2'b01, 5'd0, 5'd9, 2'd0);
        cycle();
        check("r9_next_data", 64'(rd_resp_data[31:0]), 64'h55);

        idle();
        do_issue(5'd11, 3'd2);
        cycle();
        idle();
        do_commit(5'd11, 3'd2, 32'h77);
        do_read(2'b01, 5'd0, 5'd11, 2'd0);
        cycle();
`ifdef RENAME_REG_FILE_BYPASS_EN
        check("r11_same_busy", 64'(rd_resp_busy[0]), 64'h0);
        check("r11_same_data", 64'(rd_resp_data[31:0]), 64'h77);
`else
        check("r11_same_busy", 64'(rd_resp_busy[0]), 64'h1);
        check("r11_same_data", 64'(rd_resp_data[31:0]), 64'h0);
`endif

        // rdy_in low freezes everything
        idle();
        do_read(2'b01, 5'd0, 5'd9, 2'd1);
        cycle();
        check("pre_stall_index", 64'(rd_resp_index), 64'h1);
        idle();
        rdy_in = 1'b0;
        do_issue(5'd12, 3'd1);
        do_commit(5'd13, 3'd0, 32'h99);
        do_read(2'b11, 5'd13, 5'd12, 2'd3);
        cycle();
        check("stall_valid", 64'(rd_resp_valid), 64'h0);
        check("stall_index", 64'(rd_resp_index), 64'h1);
        rdy_in = 1'b1;
        idle();
        do_read(2'b11, 5'd13, 5'd12, 2'd2);
        cycle();
        check("post_stall_busy",  64'(rd_resp_busy), 64'h0);
        check("post_stall_data",  64'(rd_resp_data), 64'h0);
        check("post_stall_index", 64'(rd_resp_index), 64'h2);

        // Asynchronous reset mid-cycle with a request in flight
        idle();
        do_read(2'b11, 5'd9, 5'd5, 2'd3);
        cycle();
        check("pre_reset_data", 64'(rd_resp_data), {32'h55, 32'h22});
        #3;
        rst_in = 1'b1;
        #1;
        check("async_valid", 64'(rd_resp_valid), 64'h0);
        check("async_data",  64'(rd_resp_data), 64'h0);
        check("async_index", 64'(rd_resp_index), 64'h0);
        cycle();
        rst_in = 1'b0;
        idle();
        cycle();
        check("post_reset_valid", 64'(rd_resp_valid), 64'h0);
        do_read(2'b11, 5'd7, 5'd5, 2'd0);
        cycle();
        check("post_reset_busy", 64'(rd_resp_busy), 64'h0);
        check("post_reset_data", 64'(rd_resp_data), 64'h0);
        check("post_reset_tag",  64'(rd_resp_tag), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
